color_match_filter: RTL and testbench
=====================================

# color_match_filter

Parametrised successor to the single-pixel green classifier in the video path. It classifies each incoming RGB pixel against programmable thresholds in one of two modes. A classification is accepted only after a run of consecutive matching pixels within a line, which suppresses single-pixel noise. It also counts accepted pixels per frame for the target-tracking logic downstream. It sits between the camera pixel stream and the tracking and overlay blocks.

## Interface
- DW, 10: colour channel width (bits).
- RUN_LEN, 4: consecutive raw matches needed before the filtered flag asserts; legal range 1..255.
- CNT_W, 20: width of the per-frame match counter.

- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pixel qualifier; pixel fields are ignored when low.
- in_sol  in  1  first pixel of a line; qualified by in_valid.
- in_sof  in  1  first pixel of a frame (implies sol); qualified by in_valid.
- red_in, green_in, blue_in  in  DW each  pixel channels, unsigned.
- mode  in  1  0 = threshold mode, 1 = dominance mode.
- red_thr, blue_thr  in  DW  mode-0 thresholds.
- margin  in  DW  mode-1 dominance margin.
- out_valid  out  1  in_valid delayed 2 cycles.
- match_raw  out  1  unfiltered classification of the pixel on out_valid.
- match_filt  out  1  run-filtered classification of the pixel on out_valid.
- frame_count  out  CNT_W  accepted-pixel total of the last completed frame.
- count_valid  out  1  one-cycle pulse when frame_count updates.

## Operation
- Stage 1 registers the raw compare, a valid bit, and the sol/sof flags. mode, thresholds and margin are sampled with the pixel, so changes apply to the next pixel.
- Mode 0: raw = (red_in > red_thr) && (blue_in < blue_thr), both strict.
- Mode 1: raw = (green_in > red_in + margin) && (green_in > blue_in + margin).
  - Sums are computed at DW+1 bits, so a sum that overflows fails the compare.
- Stage 2 keeps a run counter of 8 bits that saturates at RUN_LEN. The update order is:
  - On a pixel with sol or sof, the counter first clears.
  - The counter then increments if raw=1; otherwise it clears.
  - match_filt = raw && (updated counter >= RUN_LEN).
- Pixels with valid=0 (bubbles) leave the run counter, the accumulator and all outputs except out_valid unchanged.
- Frame accumulator, CNT_W bits, saturates at all-ones:
  - It adds 1 for each pixel with match_filt=1.
  - On a stage-2 pixel with sof: frame_count takes the accumulator value excluding this pixel, and count_valid pulses.
  - The accumulator then restarts at this pixel's match_filt (0 or 1).
- The first sof after reset publishes 0.

## Timing
- Latency is 2 cycles from in_valid to out_valid/match_raw/match_filt. Throughput is 1 pixel per cycle; there is no backpressure.
- count_valid is asserted in the same cycle as out_valid for the sof pixel. frame_count changes only in that cycle.
- Reset values: out_valid, match_raw, match_filt and count_valid are 0; frame_count is 0. The run counter, accumulator and pipeline valids are also cleared.
- Reset mid-frame discards the partial accumulator. No count_valid is issued until the next sof.
- sol and sof together on a pixel are treated as sof (which includes the run clear).

## Configuration
- COLOR_MATCH_HOLD_EN defined: release hysteresis is enabled.
  - Once match_filt is 1 in a line, it stays 1 for up to RUN_LEN-1 further valid pixels with raw=0, tracked by a hold counter.
  - A raw=1 pixel during the hold reloads the hold counter and keeps the run counter at saturation.
  - The hold is cleared by sol/sof and by reset.
  - Held pixels count toward the accumulator.
- COLOR_MATCH_HOLD_EN undefined: match_filt drops on the first raw=0 pixel, exactly as in Operation. No hold logic is built.

## Test plan
- Mode 0, red_thr=512, blue_thr=256:
  - Pixel R=513, B=255 -> match_raw=1 two cycles later.
  - Pixel R=512, B=255 -> match_raw=0.
- Mode 1, margin=100, G=1000, R=899, B=0 -> match_raw=1. With R=900 -> match_raw=0. With DW=10, G=1023, R=1000, margin=100 -> 0 (overflow case).
- RUN_LEN=4, one line of raw pattern 1,1,1,1,1,0,1:
  - Without the macro -> match_filt 0,0,0,1,1,0,0.
  - With COLOR_MATCH_HOLD_EN -> 0,0,0,1,1,1,1.
- A run of 3 matches at the end of a line, followed by sol with 1 match -> match_filt stays 0 (the run does not carry across lines). Bubbles inserted mid-run do not break the run.
- Frame with 37 accepted pixels, then sof -> count_valid pulses once with frame_count=37. With CNT_W=4 and 20 accepted pixels -> frame_count=15.
- rst_n low for 1 cycle mid-frame after 10 accepted pixels -> all outputs 0 immediately. The next sof publishes only post-reset matches.

Source files
------------

// File: rtl/color_match_filter.sv
// Two-stage RGB pixel classifier with per-line run filtering and a per-frame accepted-pixel counter.
// Optional release hysteresis on the filtered flag is built when COLOR_MATCH_HOLD_EN is defined.
module color_match_filter #(
  parameter int DW      = 10,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sol,
  input  logic             in_sof,
  input  logic [DW-1:0]    red_in,
  input  logic [DW-1:0]    green_in,
  input  logic [DW-1:0]    blue_in,
  input  logic             mode,
  input  logic [DW-1:0]    red_thr,
  input  logic [DW-1:0]    blue_thr,
  input  logic [DW-1:0]    margin,
  output logic             out_valid,
  output logic             match_raw,
  output logic             match_filt,
  output logic [CNT_W-1:0] frame_count,
  output logic             count_valid
);

  localparam logic [7:0]       RUN_MAX = 8'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Stage 1: raw compare and line/frame markers
  logic          s1_valid_q, s1_valid_d;
  logic          s1_raw_q, s1_raw_d;
  logic          s1_sol_q, s1_sol_d;
  logic          s1_sof_q, s1_sof_d;
  logic [DW:0]   g_ext, sum_r, sum_b;
  logic          raw_now;

  // Stage 2: run filter, accumulator and outputs
  logic [7:0]       run_q, run_d, run_base, run_new;
  logic             filt_new;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             out_valid_q, out_valid_d;
  logic             match_raw_q, match_raw_d;
  logic             match_filt_q, match_filt_d;
  logic             count_valid_q, count_valid_d;
`ifdef COLOR_MATCH_HOLD_EN
  logic [7:0]       hold_q, hold_d, hold_base, hold_new;
`endif

  always_comb begin
    // Sums are one bit wider so a carry out makes the dominance test fail
    g_ext   = {1'b0, green_in};
    sum_r   = {1'b0, red_in} + {1'b0, margin};
    sum_b   = {1'b0, blue_in} + {1'b0, margin};
    if (mode) begin
      raw_now = (g_ext > sum_r) && (g_ext > sum_b);
    end else begin
      raw_now = (red_in > red_thr) && (blue_in < blue_thr);
    end
    s1_valid_d = in_valid;
    s1_raw_d   = s1_raw_q;
    s1_sol_d   = s1_sol_q;
    s1_sof_d   = s1_sof_q;
    if (in_valid) begin
      s1_raw_d = raw_now;
      s1_sol_d = in_sol | in_sof;
      s1_sof_d = in_sof;
    end
  end

  always_comb begin
    run_base = s1_sol_q ? 8'd0 : run_q;
    run_new  = 8'd0;
    filt_new = 1'b0;
    if (s1_raw_q) begin
      run_new  = (run_base >= RUN_MAX) ? RUN_MAX : run_base + 8'd1;
      filt_new = (run_new >= RUN_MAX);
    end
`ifdef COLOR_MATCH_HOLD_EN
    hold_base = s1_sol_q ? 8'd0 : hold_q;
    hold_new  = 8'd0;
    if (filt_new) begin
      hold_new = RUN_MAX - 8'd1;
    end else if (!s1_raw_q && (hold_base != 8'd0)) begin
      // Held pixel: flag stays up and the run stays saturated
      filt_new = 1'b1;
      hold_new = hold_base - 8'd1;
      run_new  = run_base;
    end
`endif
  end

  always_comb begin
    out_valid_d   = s1_valid_q;
    match_raw_d   = match_raw_q;
    match_filt_d  = match_filt_q;
    count_valid_d = 1'b0;
    frame_count_d = frame_count_q;
    acc_d         = acc_q;
    run_d         = run_q;
`ifdef COLOR_MATCH_HOLD_EN
    hold_d        = hold_q;
`endif
    if (s1_valid_q) begin
      run_d        = run_new;
`ifdef COLOR_MATCH_HOLD_EN
      hold_d       = hold_new;
`endif
      match_raw_d  = s1_raw_q;
      match_filt_d = filt_new;
      if (s1_sof_q) begin
        // Publish the finished frame, then restart with this pixel's result
        frame_count_d = acc_q;
        count_valid_d = 1'b1;
        acc_d         = {{(CNT_W-1){1'b0}}, filt_new};
      end else if (filt_new && (acc_q != {CNT_W{1'b1}})) begin
        acc_d = acc_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_raw_q      <= 1'b0;
      s1_sol_q      <= 1'b0;
      s1_sof_q      <= 1'b0;
      run_q         <= 8'd0;
      acc_q         <= '0;
      frame_count_q <= '0;
      out_valid_q   <= 1'b0;
      match_raw_q   <= 1'b0;
      match_filt_q  <= 1'b0;
      count_valid_q <= 1'b0;
`ifdef COLOR_MATCH_HOLD_EN
      hold_q        <= 8'd0;
`endif
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_raw_q      <= s1_raw_d;
      s1_sol_q      <= s1_sol_d;
      s1_sof_q      <= s1_sof_d;
      run_q         <= run_d;
      acc_q         <= acc_d;
      frame_count_q <= frame_count_d;
      out_valid_q   <= out_valid_d;
      match_raw_q   <= match_raw_d;
      match_filt_q  <= match_filt_d;
      count_valid_q <= count_valid_d;
`ifdef COLOR_MATCH_HOLD_EN
      hold_q        <= hold_d;
`endif
    end
  end

  assign out_valid   = out_valid_q;
  assign match_raw   = match_raw_q;
  assign match_filt  = match_filt_q;
  assign frame_count = frame_count_q;
  assign count_valid = count_valid_q;

endmodule

// File: tb/tb_color_match_filter.sv
// Directed bench for color_match_filter: a default instance plus a CNT_W=4 instance on the same stream.
// Expected values track the hold variant when COLOR_MATCH_HOLD_EN is defined.
module tb_color_match_filter;

`ifdef COLOR_MATCH_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_sol = 1'b0, in_sof = 1'b0;
  logic [9:0] red_in = '0, green_in = '0, blue_in = '0;
  logic       mode = 1'b0;
  logic [9:0] red_thr = '0, blue_thr = '0, margin = '0;

  logic        out_valid, match_raw, match_filt, count_valid;
  logic [19:0] frame_count;
  logic        out_valid4, match_raw4, match_filt4, count_valid4;
  logic [3:0]  frame_count4;

  logic       cfg_mode = 1'b0;
  logic [9:0] cfg_rt = 10'd512, cfg_bt = 10'd256, cfg_mg = 10'd100;

  int total = 0;
  int bad = 0;
  int pix_n = 0;

  // {valid, raw, filt, count_valid, frame_count[19:0], frame_count4[3:0]}
  logic [27:0] exp_q[$];
  logic        last_raw = 1'b0, last_filt = 1'b0;
  logic [19:0] last_fc = '0;
  logic [3:0]  last_fc4 = '0;

  always #5 clk = ~clk;

  color_match_filter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sol(in_sol), .in_sof(in_sof),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .mode(mode),
    .red_thr(red_thr), .blue_thr(blue_thr), .margin(margin),
    .out_valid(out_valid), .match_raw(match_raw), .match_filt(match_filt),
    .frame_count(frame_count), .count_valid(count_valid)
  );

  color_match_filter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sol(in_sol), .in_sof(in_sof),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .mode(mode),
    .red_thr(red_thr), .blue_thr(blue_thr), .margin(margin),
    .out_valid(out_valid4), .match_raw(match_raw4), .match_filt(match_filt4),
    .frame_count(frame_count4), .count_valid(count_valid4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pop_check();
    logic [27:0] e;
    e = exp_q.pop_front();
    chk($sformatf("c%0d out_valid", pix_n), 32'(out_valid), 32'(e[27]));
    chk($sformatf("c%0d match_raw", pix_n), 32'(match_raw), 32'(e[26]));
    chk($sformatf("c%0d match_filt", pix_n), 32'(match_filt), 32'(e[25]));
    chk($sformatf("c%0d count_valid", pix_n), 32'(count_valid), 32'(e[24]));
    chk($sformatf("c%0d frame_count", pix_n), 32'(frame_count), 32'(e[23:4]));
    chk($sformatf("c%0d count_valid4", pix_n), 32'(count_valid4), 32'(e[24]));
    chk($sformatf("c%0d frame_count4", pix_n), 32'(frame_count4), 32'(e[3:0]));
  endtask

  // One pixel slot: check the output of the pixel driven two slots ago, then drive this one.
  task automatic cyc(input logic v, input logic sol, input logic sof,
                     input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                     input logic eraw, input logic efilt, input int pub);
    @(negedge clk);
    pop_check();
    pix_n++;
    mode     = cfg_mode;
    red_thr  = cfg_rt;
    blue_thr = cfg_bt;
    margin   = cfg_mg;
    in_valid = v;
    in_sol   = sol;
    in_sof   = sof;
    red_in   = r;
    green_in = g;
    blue_in  = b;
    if (v && sof) begin
      last_fc  = 20'(pub);
      last_fc4 = (pub > 15) ? 4'd15 : 4'(pub);
    end
    if (v) begin
      last_raw  = eraw;
      last_filt = efilt;
    end
    exp_q.push_back({v, last_raw, last_filt, v & sof, last_fc, last_fc4});
  endtask

  task automatic px(input logic sol, input logic sof, input logic [9:0] r, input logic [9:0] g,
                    input logic [9:0] b, input logic eraw, input logic efilt, input int pub);
    cyc(1'b1, sol, sof, r, g, b, eraw, efilt, pub);
  endtask

  task automatic bub();
    cyc(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 0);
  endtask

  // Mode-0 matching pixel (R=600, B=100) and non-matching pixel (R=100, B=100)
  task automatic m(input logic sol, input logic efilt);
    px(sol, 1'b0, 10'd600, 10'd0, 10'd100, 1'b1, efilt, 0);
  endtask

  task automatic n(input logic sol, input logic sof, input logic efilt, input int pub);
    px(sol, sof, 10'd100, 10'd0, 10'd100, 1'b0, efilt, pub);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    in_sof   = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst match_raw", 32'(match_raw), 32'd0);
    chk("rst match_filt", 32'(match_filt), 32'd0);
    chk("rst count_valid", 32'(count_valid), 32'd0);
    chk("rst frame_count", 32'(frame_count), 32'd0);
    chk("rst frame_count4", 32'(frame_count4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(28'd0);
    exp_q.push_back(28'd0);
    last_raw  = 1'b0;
    last_filt = 1'b0;
    last_fc   = '0;
    last_fc4  = '0;
  endtask

  initial begin
    do_reset();

    // Mode 0 strict thresholds; the first sof publishes 0
    cfg_mode = 1'b0; cfg_rt = 10'd512; cfg_bt = 10'd256; cfg_mg = 10'd100;
    px(1'b0, 1'b1, 10'd513, 10'd0, 10'd255, 1'b1, 1'b0, 0);
    px(1'b1, 1'b0, 10'd512, 10'd0, 10'd255, 1'b0, 1'b0, 0);
    px(1'b1, 1'b0, 10'd600, 10'd0, 10'd256, 1'b0, 1'b0, 0);

    // Mode 1 dominance, including the wide-sum case
    cfg_mode = 1'b1;
    px(1'b1, 1'b0, 10'd899, 10'd1000, 10'd0, 1'b1, 1'b0, 0);
    px(1'b1, 1'b0, 10'd900, 10'd1000, 10'd0, 1'b0, 1'b0, 0);
    px(1'b1, 1'b0, 10'd1000, 10'd1023, 10'd0, 1'b0, 1'b0, 0);
    px(1'b1, 1'b0, 10'd0, 10'd1000, 10'd899, 1'b1, 1'b0, 0);
    px(1'b1, 1'b0, 10'd0, 10'd1000, 10'd900, 1'b0, 1'b0, 0);

    // Run filter: raw 1,1,1,1,1,0,1
    cfg_mode = 1'b0;
    m(1'b1, 1'b0); m(1'b0, 1'b0); m(1'b0, 1'b0); m(1'b0, 1'b1); m(1'b0, 1'b1);
    n(1'b0, 1'b0, HOLD, 0);
    m(1'b0, HOLD);

    // Run does not carry across a line start
    m(1'b1, 1'b0); m(1'b0, 1'b0); m(1'b0, 1'b0); m(1'b1, 1'b0);

    // Bubbles inside a run keep it intact
    m(1'b1, 1'b0); m(1'b0, 1'b0); bub(); bub(); m(1'b0, 1'b0); m(1'b0, 1'b1);
    n(1'b1, 1'b0, 1'b0, 0);

    // Publish this frame (2+1 accepted, or 4+1 with hold), then a 37-pixel frame
    n(1'b0, 1'b1, 1'b0, HOLD ? 5 : 3);
    for (int i = 0; i < 40; i++) m(1'b0, 1'(i >= 3));
    n(1'b0, 1'b1, 1'b0, 37);
    for (int i = 0; i < 23; i++) m(1'b0, 1'(i >= 3));
    n(1'b0, 1'b1, 1'b0, 20);

    // 10 accepted, then reset mid-frame; next sof only counts post-reset matches
    for (int i = 0; i < 13; i++) m(1'b0, 1'(i >= 3));
    do_reset();
    n(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) m(1'b0, 1'(i >= 3));
    n(1'b0, 1'b1, 1'b0, 3);
    bub();
    bub();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
